// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, memory freeze, redirect flush and halt,
// with saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             idex_dREN,
   input  logic [4:0]       idex_wsel,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_rt_used,
   input  logic             ex_redirect,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, HALTED = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             memfreeze, loaduse;
   logic             stall_evt, flush_evt;

   assign memfreeze = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign loaduse   = idex_dREN & (idex_wsel != 5'd0) &
                      ((idex_wsel == id_rs) | (id_rt_used & (idex_wsel == id_rt)));

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      flush_evt  = 1'b0;
      state_d    = state_q;
      if (!RST && state_q != HALTED && !memfreeze) begin
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
         state_d  = RUN;
         if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
         end else if (loaduse && state_q == RUN) begin
            idex_flush = 1'b1;
            state_d    = LU_STALL;
         end else if (!ihit) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
         end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
         end
         // halt only commits once the memory stage is no longer frozen
         if (memwb_halt) state_d = HALTED;
      end
   end

   assign stall_evt = (state_q != HALTED) & ~pc_en;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush_evt && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
